// File: rtl/regfile_mp.sv
// Parametrised register file: two combinational read ports, one write port,
// per-register valid bits and a sequenced post-reset clear sweep.
// Optional write-through bypass is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int n     = 16,
  parameter int nregs = 8,
  localparam int aw   = $clog2(nregs)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [n-1:0]  data_in,
  input  logic [aw-1:0] writenum,
  input  logic          write,
  input  logic [aw-1:0] readnum_a,
  input  logic [aw-1:0] readnum_b,
  output logic [n-1:0]  data_out_a,
  output logic [n-1:0]  data_out_b,
  output logic          valid_a,
  output logic          valid_b,
  output logic          busy,
  output logic          write_ok
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // One extra bit so the index range check also works when nregs is a power of two.
  localparam logic [aw:0]   nregs_ext = (aw+1)'(nregs);
  localparam logic [aw-1:0] last_idx  = aw'(nregs - 1);

  state_t               state_reg;
  logic [aw-1:0]        idx_reg;
  logic                 busy_reg;
  logic [nregs-1:0]     vbits_reg;
  logic [n-1:0]         regs [nregs];

  logic                 wr_en;
  logic [aw-1:0]        wr_addr;
  logic [n-1:0]         wr_data;

  logic [aw-1:0]        rd_idx   [2];
  logic [n-1:0]         rd_data  [2];
  logic                 rd_valid [2];

  assign busy     = busy_reg;
  assign write_ok = write & ~busy_reg & ({1'b0, writenum} < nregs_ext);

  // Control FSM and valid bits; the array itself is never reset directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      idx_reg   <= '0;
      busy_reg  <= 1'b1;
      vbits_reg <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          vbits_reg[idx_reg] <= 1'b0;
          if (idx_reg == last_idx) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            idx_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        IDLE: begin
          if (write_ok) begin
            vbits_reg[writenum] <= 1'b1;
          end
        end
        default: begin
          state_reg <= CLEAR;
          idx_reg   <= '0;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  // Single array write port shared by the clear sweep and normal writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!reset) begin
      if (state_reg == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = idx_reg;
      end else if (write_ok) begin
        wr_en   = 1'b1;
        wr_addr = writenum;
        wr_data = data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_idx[0] = readnum_a;
  assign rd_idx[1] = readnum_b;

  // Read ports are masked to zero while the sweep runs or the index is out of range.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi]  = '0;
        rd_valid[gi] = 1'b0;
        if (!busy_reg && ({1'b0, rd_idx[gi]} < nregs_ext)) begin
          rd_data[gi]  = regs[rd_idx[gi]];
          rd_valid[gi] = vbits_reg[rd_idx[gi]];
        end
`ifdef REGFILE_MP_BYPASS_EN
        if (write_ok && (rd_idx[gi] == writenum)) begin
          rd_data[gi]  = data_in;
          rd_valid[gi] = 1'b1;
        end
`endif
      end
    end
  endgenerate

  assign data_out_a = rd_data[0];
  assign data_out_b = rd_data[1];
  assign valid_a    = rd_valid[0];
  assign valid_b    = rd_valid[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: an 8-entry and a 6-entry instance.
module tb_regfile_mp;

  logic        clk;
  int          tests_run;
  int          tests_failed;

  // 8-register instance
  logic        reset8, write8;
  logic [15:0] data_in8;
  logic [2:0]  writenum8, readnum_a8, readnum_b8;
  logic [15:0] data_out_a8, data_out_b8;
  logic        valid_a8, valid_b8, busy8, write_ok8;

  // 6-register instance
  logic        reset6, write6;
  logic [15:0] data_in6;
  logic [2:0]  writenum6, readnum_a6, readnum_b6;
  logic [15:0] data_out_a6, data_out_b6;
  logic        valid_a6, valid_b6, busy6, write_ok6;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit bypass = 1'b1;
`else
  localparam bit bypass = 1'b0;
`endif

  regfile_mp #(.n(16), .nregs(8)) dut8 (
    .clk(clk), .reset(reset8), .data_in(data_in8), .writenum(writenum8),
    .write(write8), .readnum_a(readnum_a8), .readnum_b(readnum_b8),
    .data_out_a(data_out_a8), .data_out_b(data_out_b8),
    .valid_a(valid_a8), .valid_b(valid_b8), .busy(busy8), .write_ok(write_ok8)
  );

  regfile_mp #(.n(16), .nregs(6)) dut6 (
    .clk(clk), .reset(reset6), .data_in(data_in6), .writenum(writenum6),
    .write(write6), .readnum_a(readnum_a6), .readnum_b(readnum_b6),
    .data_out_a(data_out_a6), .data_out_b(data_out_b6),
    .valid_a(valid_a6), .valid_b(valid_b6), .busy(busy6), .write_ok(write_ok6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    reset8 = 1'b1; write8 = 1'b0;
    step(); #1;
    tests_run++;
    if (busy8 !== 1'b1 || write_ok8 !== 1'b0 || data_out_a8 !== 16'h0 || valid_a8 !== 1'b0 ||
        data_out_b8 !== 16'h0 || valid_b8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b wok=%b a=%h va=%b b=%h vb=%b, exp busy=1 wok=0 a=0000 va=0 b=0000 vb=0",
               busy8, write_ok8, data_out_a8, valid_a8, data_out_b8, valid_b8);
    end
    reset8 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step(); #1;
      tests_run++;
      if (busy8 !== (e < 8)) begin
        tests_failed++;
        $display("FAIL sweep_busy_edge%0d: got %b exp %b", e, busy8, (e < 8));
      end
    end
    for (int r = 0; r < 8; r++) begin
      step();
      readnum_a8 = 3'(r); readnum_b8 = 3'(7 - r);
      #1;
      tests_run++;
      if (data_out_a8 !== 16'h0 || valid_a8 !== 1'b0 || data_out_b8 !== 16'h0 || valid_b8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL cleared_r%0d: got a=%h va=%b b=%h vb=%b exp all zero",
                 r, data_out_a8, valid_a8, data_out_b8, valid_b8);
      end
    end
    $display("[TB] reset sweep on 8-entry instance done");
  endtask

  task automatic test_write_read();
    step();
    write8 = 1'b1; writenum8 = 3'd3; data_in8 = 16'hBEEF;
    #1;
    tests_run++;
    if (write_ok8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_ok_r3: got %b exp 1", write_ok8);
    end
    step();
    write8 = 1'b0; readnum_a8 = 3'd3; readnum_b8 = 3'd4;
    #1;
    tests_run++;
    if (data_out_a8 !== 16'hBEEF || valid_a8 !== 1'b1 || data_out_b8 !== 16'h0 || valid_b8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_r3_r4: got a=%h va=%b b=%h vb=%b exp a=beef va=1 b=0000 vb=0",
               data_out_a8, valid_a8, data_out_b8, valid_b8);
    end
    readnum_b8 = 3'd3;
    #1;
    tests_run++;
    if (data_out_b8 !== 16'hBEEF || valid_b8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_same_reg_b: got b=%h vb=%b exp beef 1", data_out_b8, valid_b8);
    end
    $display("[TB] write R3=beef, read back on both ports");
  endtask

  task automatic test_write_busy();
    step();
    reset8 = 1'b1;
    step();
    reset8 = 1'b0;
    step(); step();
    write8 = 1'b1; writenum8 = 3'd2; data_in8 = 16'h1234;
    readnum_a8 = 3'd3;
    #1;
    tests_run++;
    if (write_ok8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_ok_busy: got %b exp 0", write_ok8);
    end
    tests_run++;
    if (data_out_a8 !== 16'h0 || valid_a8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_mask_r3: got a=%h va=%b exp 0000 0", data_out_a8, valid_a8);
    end
    step();
    write8 = 1'b0;
    for (int k = 0; k < 20 && busy8 === 1'b1; k++) step();
    #1;
    tests_run++;
    if (busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_timeout: busy still %b after 20 cycles, exp 0", busy8);
    end
    readnum_a8 = 3'd2;
    #1;
    tests_run++;
    if (data_out_a8 !== 16'h0 || valid_a8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL dropped_write_r2: got a=%h va=%b exp 0000 0", data_out_a8, valid_a8);
    end
    $display("[TB] write during sweep dropped");
  endtask

  task automatic test_hazard();
    step();
    write8 = 1'b1; writenum8 = 3'd5; data_in8 = 16'h00AA;
    step();
    writenum8 = 3'd5; data_in8 = 16'h5555; readnum_a8 = 3'd5; readnum_b8 = 3'd4;
    #1;
    tests_run++;
    if (data_out_a8 !== (bypass ? 16'h5555 : 16'h00AA) || valid_a8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL hazard_r5: got a=%h va=%b exp %h 1", data_out_a8, valid_a8,
               (bypass ? 16'h5555 : 16'h00AA));
    end
    tests_run++;
    if (data_out_b8 !== 16'h0 || valid_b8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL hazard_other_port: got b=%h vb=%b exp 0000 0", data_out_b8, valid_b8);
    end
    step();
    writenum8 = 3'd6; data_in8 = 16'h6666; readnum_b8 = 3'd6;
    #1;
    tests_run++;
    if (data_out_a8 !== 16'h5555 || valid_a8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_hazard_r5: got a=%h va=%b exp 5555 1", data_out_a8, valid_a8);
    end
    tests_run++;
    if (data_out_b8 !== (bypass ? 16'h6666 : 16'h0) || valid_b8 !== bypass) begin
      tests_failed++;
      $display("FAIL hazard_fresh_r6: got b=%h vb=%b exp %h %b", data_out_b8, valid_b8,
               (bypass ? 16'h6666 : 16'h0), bypass);
    end
    step();
    write8 = 1'b0;
    #1;
    tests_run++;
    if (data_out_b8 !== 16'h6666 || valid_b8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_hazard_r6: got b=%h vb=%b exp 6666 1", data_out_b8, valid_b8);
    end
    $display("[TB] same-cycle read/write hazard, bypass=%0d", bypass);
  endtask

  task automatic test_reset_mid();
    int edges;
    step();
    write8 = 1'b1; writenum8 = 3'd7; data_in8 = 16'h7777;
    step();
    write8 = 1'b0; readnum_a8 = 3'd7;
    #1;
    tests_run++;
    if (data_out_a8 !== 16'h7777 || valid_a8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL preload_r7: got a=%h va=%b exp 7777 1", data_out_a8, valid_a8);
    end
    reset8 = 1'b1;
    step();
    reset8 = 1'b0;
    step(); step(); step();
    #1;
    tests_run++;
    if (data_out_a8 !== 16'h0 || valid_a8 !== 1'b0 || busy8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_sweep_mask: got a=%h va=%b busy=%b exp 0000 0 1", data_out_a8, valid_a8, busy8);
    end
    reset8 = 1'b1;
    step();
    reset8 = 1'b0;
    edges = 0;
    for (int k = 0; k < 20 && busy8 === 1'b1; k++) begin
      step();
      edges++;
    end
    #1;
    tests_run++;
    if (edges !== 8 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_sweep_len: got %0d edges busy=%b exp 8 edges busy=0", edges, busy8);
    end
    tests_run++;
    if (data_out_a8 !== 16'h0 || valid_a8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL r7_after_restart: got a=%h va=%b exp 0000 0", data_out_a8, valid_a8);
    end
    $display("[TB] reset mid-sweep restarts the sweep");
  endtask

  task automatic test_nregs6();
    int edges;
    step();
    reset6 = 1'b1;
    step();
    reset6 = 1'b0;
    edges = 0;
    for (int k = 0; k < 20 && busy6 === 1'b1; k++) begin
      step();
      edges++;
    end
    #1;
    tests_run++;
    if (edges !== 6 || busy6 !== 1'b0) begin
      tests_failed++;
      $display("FAIL sweep6_len: got %0d edges busy=%b exp 6 edges busy=0", edges, busy6);
    end
    write6 = 1'b1; writenum6 = 3'd6; data_in6 = 16'hFFFF;
    #1;
    tests_run++;
    if (write_ok6 !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_ok_oob: got %b exp 0", write_ok6);
    end
    step();
    write6 = 1'b0;
    for (int r = 0; r < 6; r++) begin
      readnum_b6 = 3'(r);
      #1;
      tests_run++;
      if (data_out_b6 !== 16'h0 || valid_b6 !== 1'b0) begin
        tests_failed++;
        $display("FAIL oob_no_change_r%0d: got b=%h vb=%b exp 0000 0", r, data_out_b6, valid_b6);
      end
    end
    step();
    write6 = 1'b1; writenum6 = 3'd5; data_in6 = 16'h5A5A;
    #1;
    tests_run++;
    if (write_ok6 !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_ok_r5_n6: got %b exp 1", write_ok6);
    end
    step();
    write6 = 1'b0; readnum_a6 = 3'd7; readnum_b6 = 3'd5;
    #1;
    tests_run++;
    if (data_out_a6 !== 16'h0 || valid_a6 !== 1'b0) begin
      tests_failed++;
      $display("FAIL oob_read7: got a=%h va=%b exp 0000 0", data_out_a6, valid_a6);
    end
    tests_run++;
    if (data_out_b6 !== 16'h5A5A || valid_b6 !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_r5_n6: got b=%h vb=%b exp 5a5a 1", data_out_b6, valid_b6);
    end
    $display("[TB] 6-entry instance: sweep length, out-of-range write/read");
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset8 = 1'b0; write8 = 1'b0; data_in8 = '0; writenum8 = '0; readnum_a8 = '0; readnum_b8 = '0;
    reset6 = 1'b0; write6 = 1'b0; data_in6 = '0; writenum6 = '0; readnum_a6 = '0; readnum_b6 = '0;
    test_reset();
    test_write_read();
    test_write_busy();
    test_hazard();
    test_reset_mid();
    test_nregs6();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
